ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register; consumes its registered operands, immediate, instruction word and control bits.
- Contains operand forwarding muxes, ALU control decode and a 32-bit ALU.
- Contains the EX/MEM pipeline register that feeds the memory stage.
- Optionally adds an iterative multiplier that stalls upstream stages while it runs.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
idex_read_data_1  in  32  rs1 register-file value
idex_read_data_2  in  32  rs2 register-file value
idex_immgen  in  32  sign-extended immediate
idex_inst  in  32  instruction word; funct3=[14:12], funct7=[31:25]
idex_rs1  in  5  source register 1
idex_rs2  in  5  source register 2
idex_rd  in  5  destination register
idex_alusrc  in  1  1 = ALU operand B is the immediate
idex_aluop  in  2  00 add, 01 sub/branch compare, 10 decode funct fields
idex_memread  in  1  load control
idex_memwrite  in  1  store control
idex_regwrite  in  1  write-back enable
idex_memtoreg  in  1  write-back source select
memwb_rd  in  5  MEM/WB destination register
memwb_regwrite  in  1  MEM/WB write enable
memwb_write_data  in  32  final write-back value
ex_busy  out  1  combinational; 1 = hold PC, IF/ID and ID/EX
exmem_alu_result  out  32  registered ALU or multiply result
exmem_write_data  out  32  registered forwarded rs2 value (store data)
exmem_rd  out  5  registered destination
exmem_zero  out  1  registered: ALU result == 0
exmem_memread  out  1  registered control
exmem_memwrite  out  1  registered control
exmem_regwrite  out  1  registered control
exmem_memtoreg  out  1  registered control

Behaviour:
- Reset: rst_n low at posedge clears every exmem_* output to 0, forces the FSM to IDLE and the counter to 0, so ex_busy=0. Reset during a multiply aborts it and no result is written.
- Forwarding for operand A:
  - If exmem_regwrite and exmem_rd!=0 and exmem_rd==idex_rs1, use exmem_alu_result.
  - Else if memwb_regwrite and memwb_rd!=0 and memwb_rd==idex_rs1, use memwb_write_data.
  - Else use idex_read_data_1.
  - EX/MEM has priority over MEM/WB.
- Forwarding for fwd_B: same rules using idex_rs2.
- Load-use hazards are not detected here; the upstream hazard unit inserts the bubble.
- ALU operand B = idex_alusrc ? idex_immgen : fwd_B.
- exmem_write_data always takes fwd_B, regardless of alusrc.
- ALU control:
  - aluop 00: ADD.
  - aluop 01: SUB.
  - aluop 10, by funct3: 000 ADD, or SUB when inst[30]=1 and alusrc=0; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL, or SRA when inst[30]=1; 110 OR; 111 AND.
  - aluop 11: result 0.
- Shift amount is B[4:0]. All arithmetic wraps modulo 2^32.
- exmem_zero = (ALU result == 0).
- Non-stalled operation: the EX/MEM register loads every cycle with latency 1.
- No valid/ready handshake; flow control is ex_busy only.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined:
  - An instruction with aluop=10, alusrc=0, funct7=0000001 and funct3=000 is a MUL; the result is the low 32 bits of A*B.
  - FSM states are IDLE, BUSY and DONE.
  - IDLE with MUL in ID/EX (cycle N): ex_busy=1. The bubble described below is loaded into EX/MEM. Forwarded A and B are captured as multiplicand and multiplier. The accumulator is cleared, count is set to 31, and the FSM moves to BUSY.
  - BUSY (cycles N+1..N+32): ex_busy=1. One shift-add step per edge. Bubble loaded into EX/MEM each cycle. When count==0 the FSM moves to DONE; otherwise count decrements.
  - DONE (cycle N+33): ex_busy=0. EX/MEM loads the product with the held instruction's rd and control bits. exmem_zero is set from the product. FSM returns to IDLE.
  - Bubble: exmem_regwrite, exmem_memread, exmem_memwrite and exmem_memtoreg all 0; data fields hold their previous values.
  - Operands are latched at cycle N and are not re-forwarded later.
  - A MUL immediately following a MUL starts a new sequence from IDLE.
- Undefined: no multiplier state is built and ex_busy is tied to 0. funct7=0000001 is ignored and the instruction decodes by funct3 as if funct7=0.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles -> all exmem_* = 0 and ex_busy = 0.
- ADD x3 = x1 + x2 with rs1=5, rs2=7 -> exmem_alu_result = 12, exmem_zero = 0, exmem_rd = 3 on the next edge.
- Forwarding: EX/MEM has rd=1 result 100; MEM/WB has rd=1 data 55 and rd=2 data 9; ID/EX is ADD x4, x1, x2 -> result 109 (EX/MEM wins for x1, MEM/WB supplies x2). Repeat with rd=0 in EX/MEM -> no forward from EX/MEM.
- SRA with inst[30]=1, A=0x80000000, B=4 -> 0xF8000000. SLTU with A=0xFFFFFFFF, B=1 -> 0. SUB with A=B=3 -> exmem_zero = 1.
- Multiply (EX_MUL_EN defined): MUL with A=0xFFFFFFFF, B=3 -> ex_busy high 33 cycles; exmem_regwrite=0 during them; then 0xFFFFFFFD with regwrite=1. Deassert rst_n mid-multiply -> IDLE, no result written.
- Multiply (EX_MUL_EN undefined): same instruction -> ADD result 0x00000002 after 1 cycle, ex_busy stays 0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU control decode, 32-bit ALU and the EX/MEM register.
// Build with EX_MUL_EN defined to add an iterative shift-add multiplier that stalls upstream via ex_busy.
//
// Multiplier FSM (only with EX_MUL_EN):
//   state  | meaning
//   S_IDLE | normal operation; a MUL in ID/EX latches operands and raises ex_busy
//   S_BUSY | one shift-add step per edge, bubbles into EX/MEM, count 31 -> 0
//   S_DONE | product written into EX/MEM with the held instruction's rd/controls
module ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] idex_read_data_1,
   input  logic [XLEN-1:0] idex_read_data_2,
   input  logic [XLEN-1:0] idex_immgen,
   input  logic [31:0]     idex_inst,
   input  logic [4:0]      idex_rs1,
   input  logic [4:0]      idex_rs2,
   input  logic [4:0]      idex_rd,
   input  logic            idex_alusrc,
   input  logic [1:0]      idex_aluop,
   input  logic            idex_memread,
   input  logic            idex_memwrite,
   input  logic            idex_regwrite,
   input  logic            idex_memtoreg,
   input  logic [4:0]      memwb_rd,
   input  logic            memwb_regwrite,
   input  logic [XLEN-1:0] memwb_write_data,
   output logic            ex_busy,
   output logic [XLEN-1:0] exmem_alu_result,
   output logic [XLEN-1:0] exmem_write_data,
   output logic [4:0]      exmem_rd,
   output logic            exmem_zero,
   output logic            exmem_memread,
   output logic            exmem_memwrite,
   output logic            exmem_regwrite,
   output logic            exmem_memtoreg
);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ZERO
   } alu_op_t;

   logic [2:0]      funct3;
   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;
   logic [XLEN-1:0] alu_b;
   logic [4:0]      shamt;
   alu_op_t         alu_op;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] wb_result;
   logic            load_bubble;
   logic            unused_inst;

   assign funct3      = idex_inst[14:12];
   assign unused_inst = ^{idex_inst[31], idex_inst[29:15], idex_inst[11:0]};

   // EX/MEM is the younger producer, so it wins over MEM/WB
   always_comb begin
      fwd_a = idex_read_data_1;
      if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_rs1))
         fwd_a = exmem_alu_result;
      else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_rs1))
         fwd_a = memwb_write_data;
   end

   always_comb begin
      fwd_b = idex_read_data_2;
      if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idex_rs2))
         fwd_b = exmem_alu_result;
      else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idex_rs2))
         fwd_b = memwb_write_data;
   end

   assign alu_b = idex_alusrc ? idex_immgen : fwd_b;
   assign shamt = alu_b[4:0];

   // inst[30] selects SUB only for register-register forms; ADDI ignores it
   always_comb begin
      alu_op = ALU_ADD;
      case (idex_aluop)
         2'b00: alu_op = ALU_ADD;
         2'b01: alu_op = ALU_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  alu_op = (idex_inst[30] && !idex_alusrc) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = idex_inst[30] ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
         default: alu_op = ALU_ZERO;
      endcase
   end

   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD:  alu_result = fwd_a + alu_b;
         ALU_SUB:  alu_result = fwd_a - alu_b;
         ALU_SLL:  alu_result = fwd_a << shamt;
         ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
         ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (fwd_a < alu_b)};
         ALU_XOR:  alu_result = fwd_a ^ alu_b;
         ALU_SRL:  alu_result = fwd_a >> shamt;
         ALU_SRA:  alu_result = $unsigned($signed(fwd_a) >>> shamt);
         ALU_OR:   alu_result = fwd_a | alu_b;
         ALU_AND:  alu_result = fwd_a & alu_b;
         default:  alu_result = '0;
      endcase
   end

`ifdef EX_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [4:0]      count;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;
   logic            is_mul;
   logic            start_mul;
   logic            load_product;

   assign is_mul = (idex_aluop == 2'b10) && !idex_alusrc &&
                   (idex_inst[31:25] == 7'b0000001) && (funct3 == 3'b000);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (is_mul) state_nxt = S_BUSY;
         S_BUSY:  if (count == 5'd0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      start_mul    = 1'b0;
      ex_busy      = 1'b0;
      load_product = 1'b0;
      case (state)
         S_IDLE: begin
            start_mul = is_mul;
            ex_busy   = is_mul;
         end
         S_BUSY:  ex_busy = 1'b1;
         S_DONE:  load_product = 1'b1;
         default: ex_busy = 1'b0;
      endcase
   end

   // Operands are captured once at start; later forwarding changes are ignored
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= 5'd0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start_mul) begin
         count  <= 5'd31;
         mcand  <= fwd_a;
         mplier <= fwd_b;
         acc    <= '0;
      end else if (state == S_BUSY) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (count != 5'd0) count <= count - 5'd1;
      end
   end

   assign load_bubble = ex_busy;
   assign wb_result   = load_product ? acc : alu_result;
`else
   assign ex_busy     = 1'b0;
   assign load_bubble = 1'b0;
   assign wb_result   = alu_result;
`endif

   // A bubble kills the controls but leaves the data fields untouched
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exmem_alu_result <= '0;
         exmem_write_data <= '0;
         exmem_rd         <= 5'd0;
         exmem_zero       <= 1'b0;
         exmem_memread    <= 1'b0;
         exmem_memwrite   <= 1'b0;
         exmem_regwrite   <= 1'b0;
         exmem_memtoreg   <= 1'b0;
      end else if (load_bubble) begin
         exmem_memread    <= 1'b0;
         exmem_memwrite   <= 1'b0;
         exmem_regwrite   <= 1'b0;
         exmem_memtoreg   <= 1'b0;
      end else begin
         exmem_alu_result <= wb_result;
         exmem_write_data <= fwd_b;
         exmem_rd         <= idex_rd;
         exmem_zero       <= (wb_result == '0);
         exmem_memread    <= idex_memread;
         exmem_memwrite   <= idex_memwrite;
         exmem_regwrite   <= idex_regwrite;
         exmem_memtoreg   <= idex_memtoreg;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; multiplier sequences run only when EX_MUL_EN is defined.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] idex_read_data_1, idex_read_data_2, idex_immgen, idex_inst;
   logic [4:0]  idex_rs1, idex_rs2, idex_rd;
   logic        idex_alusrc;
   logic [1:0]  idex_aluop;
   logic        idex_memread, idex_memwrite, idex_regwrite, idex_memtoreg;
   logic [4:0]  memwb_rd;
   logic        memwb_regwrite;
   logic [31:0] memwb_write_data;
   logic        ex_busy;
   logic [31:0] exmem_alu_result, exmem_write_data;
   logic [4:0]  exmem_rd;
   logic        exmem_zero, exmem_memread, exmem_memwrite, exmem_regwrite, exmem_memtoreg;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .idex_read_data_1(idex_read_data_1), .idex_read_data_2(idex_read_data_2),
      .idex_immgen(idex_immgen), .idex_inst(idex_inst),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
      .idex_alusrc(idex_alusrc), .idex_aluop(idex_aluop),
      .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
      .idex_regwrite(idex_regwrite), .idex_memtoreg(idex_memtoreg),
      .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_write_data(memwb_write_data),
      .ex_busy(ex_busy),
      .exmem_alu_result(exmem_alu_result), .exmem_write_data(exmem_write_data),
      .exmem_rd(exmem_rd), .exmem_zero(exmem_zero),
      .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
      .exmem_regwrite(exmem_regwrite), .exmem_memtoreg(exmem_memtoreg)
   );

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] a, b, imm;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic        alusrc;
      logic [1:0]  aluop;
      logic [3:0]  ctrl;      // {memread, memwrite, regwrite, memtoreg}
      logic [4:0]  wb_rd;
      logic        wb_we;
      logic [31:0] wb_data;
      logic [31:0] exp_res, exp_wdata;
      logic        exp_zero;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic [6:0] f7, input logic [2:0] f3, input logic alusrc,
                               input logic [1:0] aluop, input logic [3:0] ctrl,
                               input logic [4:0] wb_rd, input logic wb_we, input logic [31:0] wb_data,
                               input logic [31:0] exp_res, input logic [31:0] exp_wdata,
                               input logic exp_zero);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.a = a; v.b = b; v.imm = imm;
      v.f7 = f7; v.f3 = f3; v.alusrc = alusrc; v.aluop = aluop; v.ctrl = ctrl;
      v.wb_rd = wb_rd; v.wb_we = wb_we; v.wb_data = wb_data;
      v.exp_res = exp_res; v.exp_wdata = exp_wdata; v.exp_zero = exp_zero;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      idex_rs1 = v.rs1; idex_rs2 = v.rs2; idex_rd = v.rd;
      idex_read_data_1 = v.a; idex_read_data_2 = v.b; idex_immgen = v.imm;
      idex_inst = {v.f7, 10'd0, v.f3, 12'h033};
      idex_alusrc = v.alusrc; idex_aluop = v.aluop;
      {idex_memread, idex_memwrite, idex_regwrite, idex_memtoreg} = v.ctrl;
      memwb_rd = v.wb_rd; memwb_regwrite = v.wb_we; memwb_write_data = v.wb_data;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, " result"}, exmem_alu_result, 32'd0);
      chk({tag, " wdata"}, exmem_write_data, 32'd0);
      chk({tag, " rd"}, {27'd0, exmem_rd}, 32'd0);
      chk({tag, " ctrl+zero"},
          {27'd0, exmem_zero, exmem_memread, exmem_memwrite, exmem_regwrite, exmem_memtoreg}, 32'd0);
      chk({tag, " busy"}, {31'd0, ex_busy}, 32'd0);
   endtask

   vec_t nop;
   logic [31:0] last_exp;

`ifdef EX_MUL_EN
   // Runs one multiply from an idle FSM; inputs stay held for the whole sequence
   task automatic run_mul(input string tag, input vec_t v, input logic [31:0] prev_res);
      int busy_cycles;
      drive(v);
      #1;
      busy_cycles = 0;
      while (ex_busy && busy_cycles < 40) begin
         busy_cycles++;
         @(posedge clk); #1;
         chk({tag, " bubble regwrite"}, {31'd0, exmem_regwrite}, 32'd0);
         if (busy_cycles == 1) chk({tag, " bubble holds result"}, exmem_alu_result, prev_res);
      end
      chk({tag, " busy cycles"}, busy_cycles, 33);
      @(posedge clk); #1;
      chk({tag, " product"}, exmem_alu_result, v.exp_res);
      chk({tag, " regwrite"}, {31'd0, exmem_regwrite}, 32'd1);
      chk({tag, " rd"}, {27'd0, exmem_rd}, {27'd0, v.rd});
      chk({tag, " zero"}, {31'd0, exmem_zero}, {31'd0, v.exp_zero});
   endtask
`endif

   initial begin
      nop = mk(0,0,0, 0,0,0, 7'h00,3'd0,0,2'b00,4'b0000, 0,0,0, 0,0,1);
      //          rs1 rs2 rd  a            b            imm          f7     f3   src op     ctrl     wbrd we wbdata  res          wdata        z
      vecs.push_back(mk(1, 2, 3,  32'd5,       32'd7,       0,           7'h00, 3'd0, 0, 2'b00, 4'b0010, 0, 0, 0,     32'd12,      32'd7,       0));
      vecs.push_back(mk(10,11,1,  32'd60,      32'd40,      0,           7'h00, 3'd0, 0, 2'b00, 4'b0010, 0, 0, 0,     32'd100,     32'd40,      0));
      vecs.push_back(mk(1, 2, 4,  32'd7777,    32'd1234,    0,           7'h00, 3'd0, 0, 2'b00, 4'b0010, 2, 1, 9,     32'd109,     32'd9,       0));
      vecs.push_back(mk(10,11,1,  32'd60,      32'd40,      0,           7'h00, 3'd0, 0, 2'b00, 4'b0010, 0, 0, 0,     32'd100,     32'd40,      0));
      vecs.push_back(mk(1, 2, 4,  32'd7777,    32'd9,       0,           7'h00, 3'd0, 0, 2'b00, 4'b0010, 1, 1, 55,    32'd109,     32'd9,       0));
      vecs.push_back(mk(10,11,0,  32'd60,      32'd40,      0,           7'h00, 3'd0, 0, 2'b00, 4'b0010, 0, 0, 0,     32'd100,     32'd40,      0));
      vecs.push_back(mk(0, 0, 5,  32'd0,       32'd0,       0,           7'h00, 3'd0, 0, 2'b00, 4'b0010, 0, 1, 999,   32'd0,       32'd0,       1));
      vecs.push_back(mk(7, 8, 6,  32'hdead,    32'h20,      0,           7'h00, 3'd0, 0, 2'b00, 4'b0000, 7, 1, 32'h10, 32'h30,     32'h20,      0));
      vecs.push_back(mk(20,21,7,  32'h80000000,32'd4,       0,           7'h20, 3'd5, 0, 2'b10, 4'b0010, 0, 0, 0,     32'hF8000000,32'd4,       0));
      vecs.push_back(mk(20,21,7,  32'h80000000,32'd4,       0,           7'h00, 3'd5, 0, 2'b10, 4'b0010, 0, 0, 0,     32'h08000000,32'd4,       0));
      vecs.push_back(mk(20,21,8,  32'hFFFFFFFF,32'd1,       0,           7'h00, 3'd3, 0, 2'b10, 4'b0010, 0, 0, 0,     32'd0,       32'd1,       1));
      vecs.push_back(mk(20,21,8,  32'hFFFFFFFF,32'd1,       0,           7'h00, 3'd2, 0, 2'b10, 4'b0010, 0, 0, 0,     32'd1,       32'd1,       0));
      vecs.push_back(mk(20,21,0,  32'd3,       32'd3,       0,           7'h00, 3'd0, 0, 2'b01, 4'b0000, 0, 0, 0,     32'd0,       32'd3,       1));
      vecs.push_back(mk(20,21,9,  32'd10,      32'd3,       0,           7'h20, 3'd0, 0, 2'b10, 4'b0010, 0, 0, 0,     32'd7,       32'd3,       0));
      vecs.push_back(mk(20,21,9,  32'd10,      32'h55,      32'd5,       7'h20, 3'd0, 1, 2'b10, 4'b0010, 0, 0, 0,     32'd15,      32'h55,      0));
      vecs.push_back(mk(20,21,10, 32'd100,     32'h55,      32'hFFFFFFFC,7'h00, 3'd0, 1, 2'b00, 4'b1011, 0, 0, 0,     32'd96,      32'h55,      0));
      vecs.push_back(mk(20,21,0,  32'h1000,    32'hCAFEBABE,32'd8,       7'h00, 3'd0, 1, 2'b00, 4'b0100, 0, 0, 0,     32'h1008,    32'hCAFEBABE,0));
      vecs.push_back(mk(20,21,11, 32'd1,       32'h3F,      0,           7'h00, 3'd1, 0, 2'b10, 4'b0010, 0, 0, 0,     32'h80000000,32'h3F,      0));
      vecs.push_back(mk(20,21,11, 32'd3,       32'h0,       32'd4,       7'h00, 3'd1, 1, 2'b10, 4'b0010, 0, 0, 0,     32'd48,      32'h0,       0));
      vecs.push_back(mk(20,21,12, 32'hF0F0F0F0,32'hFF00FF00,0,           7'h00, 3'd4, 0, 2'b10, 4'b0010, 0, 0, 0,     32'h0FF00FF0,32'hFF00FF00,0));
      vecs.push_back(mk(20,21,12, 32'hF0F0F0F0,32'hFF00FF00,0,           7'h00, 3'd6, 0, 2'b10, 4'b0010, 0, 0, 0,     32'hFFF0FFF0,32'hFF00FF00,0));
      vecs.push_back(mk(20,21,12, 32'hF0F0F0F0,32'hFF00FF00,0,           7'h00, 3'd7, 0, 2'b10, 4'b0010, 0, 0, 0,     32'hF000F000,32'hFF00FF00,0));
      vecs.push_back(mk(20,21,13, 32'd5,       32'd6,       0,           7'h00, 3'd0, 0, 2'b11, 4'b0010, 0, 0, 0,     32'd0,       32'd6,       1));
`ifndef EX_MUL_EN
      vecs.push_back(mk(20,21,14, 32'hFFFFFFFF,32'd3,       0,           7'h01, 3'd0, 0, 2'b10, 4'b0010, 0, 0, 0,     32'd2,       32'd3,       0));
`endif

      rst_n = 1'b0;
      drive(nop);
      repeat (2) @(posedge clk);
      #1;
      chk_cleared("reset");
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d busy", i), {31'd0, ex_busy}, 32'd0);
         @(posedge clk); #1;
         chk($sformatf("v%0d result", i), exmem_alu_result, vecs[i].exp_res);
         chk($sformatf("v%0d wdata", i), exmem_write_data, vecs[i].exp_wdata);
         chk($sformatf("v%0d rd", i), {27'd0, exmem_rd}, {27'd0, vecs[i].rd});
         chk($sformatf("v%0d zero", i), {31'd0, exmem_zero}, {31'd0, vecs[i].exp_zero});
         chk($sformatf("v%0d ctrl", i),
             {28'd0, exmem_memread, exmem_memwrite, exmem_regwrite, exmem_memtoreg},
             {28'd0, vecs[i].ctrl});
         last_exp = vecs[i].exp_res;
      end

`ifdef EX_MUL_EN
      run_mul("mul1", mk(20,21,9, 32'hFFFFFFFF,32'd3,0, 7'h01,3'd0,0,2'b10,4'b0010, 0,0,0,
                         32'hFFFFFFFD,32'd3,0), last_exp);
      // Second MUL presented right after DONE starts a fresh sequence
      run_mul("mul2", mk(20,21,15, 32'd7,32'd6,0, 7'h01,3'd0,0,2'b10,4'b0010, 0,0,0,
                         32'd42,32'd6,0), 32'hFFFFFFFD);

      drive(mk(20,21,16, 32'h12345,32'h100,0, 7'h01,3'd0,0,2'b10,4'b0010, 0,0,0, 0,0,0));
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(nop);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_cleared("mul abort");
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         chk($sformatf("abort c%0d result", c), exmem_alu_result, 32'd0);
      end
      chk("abort final busy", {31'd0, ex_busy}, 32'd0);
`endif

      // Reset over live, non-zero pipeline state
      drive(vecs[1]);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_cleared("late reset");
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
